// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: registered N-to-1 valid/ready merger with round-robin or fixed-priority grant; define MUXN_RR_REG_LOCK_EN for packet lock via in_last
module muxn_rr_reg #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   parameter int MODE  = 0,
   parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_sel
`ifdef MUXN_RR_REG_LOCK_EN
   ,
   input  logic [NCH-1:0]       in_last
`endif
);
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] gnt_idx;
   logic [SELW-1:0] nxt_ptr;
   logic [SELW:0]   cand;
   logic [NCH-1:0]  req;
   logic            gnt_any;
   logic            load_en;
   logic            xfer;
   logic            adv;
   assign load_en  = !out_valid || out_ready;
   assign xfer     = gnt_any && load_en && !rst;
   assign in_ready = xfer ? NCH'(1) << gnt_idx : '0;
   assign nxt_ptr  = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef MUXN_RR_REG_LOCK_EN
   logic            locked;
   logic [SELW-1:0] lock_ch;
   assign req = locked ? in_valid & (NCH'(1) << lock_ch) : in_valid;
   assign adv = xfer && in_last[gnt_idx];
   // lock onto a channel mid-packet until its last beat is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         locked  <= 1'b0;
         lock_ch <= '0;
      end else if (xfer) begin
         locked  <= !in_last[gnt_idx];
         lock_ch <= gnt_idx;
      end
   end
`else
   assign req = in_valid;
   assign adv = xfer;
`endif
   // grant: first requester scanning from ptr (round-robin) or from 0 (fixed priority)
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = ((MODE == 0) ? {1'b0, ptr} : '0) + (SELW+1)'(k);
         cand = (cand >= (SELW+1)'(NCH)) ? cand - (SELW+1)'(NCH) : cand;
         if (!gnt_any && req[cand[SELW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[SELW-1:0];
         end
      end
   end
   // output register: fill on a grant, empty when the consumer drains without refill
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
         out_sel   <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
   // round-robin pointer moves past the winner once its beat (or packet) is done
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (adv && MODE == 0)
         ptr <= nxt_ptr;
   end
endmodule

// File: tb/tb_muxn_rr_reg.sv
// tb_muxn_rr_reg: table-driven check of round-robin merger plus fixed-priority, reset and lock sequences
module tb_muxn_rr_reg;
   localparam int W = 8;
   localparam int N = 4;
   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic           out_ready;
   logic [N-1:0]   rr_ready, fp_ready;
   logic [W-1:0]   rr_data, fp_data;
   logic           rr_valid, fp_valid;
   logic [1:0]     rr_sel, fp_sel;
`ifdef MUXN_RR_REG_LOCK_EN
   logic [N-1:0]   in_last;
`endif
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] vld;
      logic       ordy;
      logic [3:0] rdy;
      logic       ov;
      logic [1:0] sel;
      logic [7:0] dat;
   } vec_t;
   vec_t tbl[20];

   always #5 clk = ~clk;

   muxn_rr_reg #(.WIDTH(W), .NCH(N), .MODE(0)) u_rr (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rr_ready),
      .out_data(rr_data), .out_valid(rr_valid), .out_ready(out_ready), .out_sel(rr_sel)
`ifdef MUXN_RR_REG_LOCK_EN
      , .in_last(in_last)
`endif
   );

   muxn_rr_reg #(.WIDTH(W), .NCH(N), .MODE(1)) u_fp (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(fp_ready),
      .out_data(fp_data), .out_valid(fp_valid), .out_ready(out_ready), .out_sel(fp_sel)
`ifdef MUXN_RR_REG_LOCK_EN
      , .in_last(in_last)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid  = 4'hF;
      out_ready = 1'b1;
      rst       = 1'b1;
`ifdef MUXN_RR_REG_LOCK_EN
      in_last   = 4'hF;
`endif
      tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
      tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
      tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
      tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
      tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
      tbl[5]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
      tbl[6]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
      tbl[7]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
      tbl[8]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
      tbl[9]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
      tbl[10] = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
      tbl[11] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 8'hA1};
      tbl[12] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd1, 8'hA1};
      tbl[13] = '{4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
      tbl[14] = '{4'h9, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
      tbl[15] = '{4'h9, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
      tbl[16] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'hA0};
      tbl[17] = '{4'h2, 1'b0, 4'h2, 1'b1, 2'd1, 8'hA1};
      tbl[18] = '{4'h2, 1'b0, 4'h0, 1'b1, 2'd1, 8'hA1};
      tbl[19] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 8'hA1};

      #1;
      chk("rst_rr_ready", 32'(rr_ready), 32'h0);
      chk("rst_fp_ready", 32'(fp_ready), 32'h0);
      tick();
      tick();
      chk("rst_rr_valid", 32'(rr_valid), 32'h0);
      chk("rst_rr_data", 32'(rr_data), 32'h0);
      chk("rst_rr_sel", 32'(rr_sel), 32'h0);
      chk("rst_fp_valid", 32'(fp_valid), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         in_valid  = tbl[i].vld;
         out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("row%0d_ready", i), 32'(rr_ready), 32'(tbl[i].rdy));
         tick();
         chk($sformatf("row%0d_valid", i), 32'(rr_valid), 32'(tbl[i].ov));
         chk($sformatf("row%0d_sel", i), 32'(rr_sel), 32'(tbl[i].sel));
         chk($sformatf("row%0d_data", i), 32'(rr_data), 32'(tbl[i].dat));
      end

      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid  = 4'hA;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("fp%0d_ready", i), 32'(fp_ready), 32'h2);
         tick();
         chk($sformatf("fp%0d_sel", i), 32'(fp_sel), 32'd1);
         chk($sformatf("fp%0d_data", i), 32'(fp_data), 32'hA1);
      end

      in_valid = 4'hF;
      rst = 1'b1;
      #1;
      chk("midrst_fp_ready", 32'(fp_ready), 32'h0);
      tick();
      chk("midrst_fp_valid", 32'(fp_valid), 32'h0);
      chk("midrst_fp_data", 32'(fp_data), 32'h0);
      rst = 1'b0;

`ifdef MUXN_RR_REG_LOCK_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid  = 4'h6;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_last = (i == 2) ? 4'h2 : 4'h0;
         #1;
         chk($sformatf("lock%0d_ready", i), 32'(rr_ready), 32'h2);
         tick();
         chk($sformatf("lock%0d_sel", i), 32'(rr_sel), 32'd1);
      end
      in_valid = 4'h4;
      in_last  = 4'h4;
      #1;
      chk("lock_rel_ready", 32'(rr_ready), 32'h4);
      tick();
      chk("lock_rel_sel", 32'(rr_sel), 32'd2);
      chk("lock_rel_data", 32'(rr_data), 32'hA2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
